// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter definitions: FSM state codes and oversampling ratio.
// The ratio matches the receiver, so both ends can run from the same baud tick.
package uart_tx_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic cnt_last(input logic [3:0] cnt);
    return cnt == 4'(UART_OVERSAMPLE - 1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU store path and the line FSM; dout is registered storage.
// Latency 1 cycle (write to empty is visible next cycle); push while full is accepted only with a pop.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with byte FIFO, bit timing from a shared 16x baud tick.
// Frame is 16*(9+STOP_BITS) ticks; writes to a full FIFO are dropped (sticky overflow) unless popped same cycle.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  tx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic       stop_q, stop_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       overflow_q, overflow_d;

  logic       pop, push, fifo_full, fifo_empty, last_stop;
  logic [7:0] fifo_dout;

  assign push       = wr_en && (!fifo_full || pop);
  assign overflow_d = overflow_q || (wr_en && !push);
  assign last_stop  = (stop_q == 1'(STOP_BITS - 1));

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        TX_IDLE:  if (!fifo_empty) state_d = TX_START;
        TX_START: if (cnt_last(cnt_q)) state_d = TX_DATA;
        TX_DATA:  if (cnt_last(cnt_q) && bit_q == 3'd7) state_d = TX_STOP;
        TX_STOP:  if (cnt_last(cnt_q) && last_stop) state_d = fifo_empty ? TX_IDLE : TX_START;
        default:  state_d = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (tick) begin
      case (state_q)
        TX_IDLE: begin
          tx_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            tx_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        TX_START: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_last(cnt_q)) begin
            tx_d  = shift_q[0];
            bit_d = '0;
            cnt_d = '0;
          end
        end
        TX_DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_last(cnt_q)) begin
            cnt_d = '0;
            if (bit_q != 3'd7) begin
              shift_d = {1'b0, shift_q[7:1]};
              tx_d    = shift_q[1];
              bit_d   = bit_q + 3'd1;
            end else begin
              tx_d   = 1'b1;
              stop_d = 1'b0;
            end
          end
        end
        TX_STOP: begin
          tx_d  = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_last(cnt_q)) begin
            cnt_d  = '0;
            stop_d = stop_q + 1'b1;
            // Back-to-back frames: the last stop tick doubles as the next start tick.
            if (last_stop) begin
              stop_d = 1'b0;
              if (!fifo_empty) begin
                pop     = 1'b1;
                shift_d = fifo_dout;
                tx_d    = 1'b0;
              end
            end
          end
        end
        default: tx_d = 1'b1;
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != TX_IDLE) || !fifo_empty;
  assign full     = fifo_full;
  assign overflow = overflow_q;

endmodule
